uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit serializer among NUM_REQ byte producers.
// Packets lock the grant until a byte marked last; CTS gates launches; stuck serializer and idle locks time out.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDX_W        = 2,
    parameter int BUSY_TIMEOUT = 15,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   grant_active,
    input  logic                   cts_in,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic                   tx_err,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_HOLD      = 3'd4
    } state_t;

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [7:0]     BUSY_LIM  = 8'(BUSY_TIMEOUT - 1);
    localparam logic [7:0]     LOCK_LIM  = 8'(LOCK_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_grant;
    logic               r_lock;
    logic [7:0]         r_timer;
    logic [7:0]         r_tx_data;

    logic               w_eligible;
    logic [NUM_REQ-1:0] w_rot;
    logic               w_sel_found;
    logic [IDX_W:0]     w_off;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [IDX_W-1:0]   w_next_ptr;
    logic               w_cur_valid;
    logic               w_cur_last;
    logic [7:0]         w_cur_data;
    logic               w_busy_expired;
    logic               w_lock_expired;
    logic               w_hold_launch;

    // Compare-and-wrap keeps indices below NUM_REQ even when it is not a power of two.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a, input logic [IDX_W:0] b);
        logic [IDX_W:0] s;
        s = {1'b0, a} + b;
        if (s >= NUM_REQ_W) s = s - NUM_REQ_W;
        return s[IDX_W-1:0];
    endfunction

    assign w_eligible  = cts_in && !tx_busy;
    assign w_cur_valid = req_valid[r_grant];
    assign w_cur_last  = req_last[r_grant];
    assign w_cur_data  = req_data[{r_grant, 3'b000} +: 8];
    assign w_next_ptr  = wrap_add(r_grant, (IDX_W+1)'(1));
    assign w_sel_idx   = wrap_add(r_ptr, w_off);

    assign w_busy_expired = (r_state == S_WAIT_BUSY) && !tx_busy && (r_timer == BUSY_LIM);
    assign w_hold_launch  = (r_state == S_HOLD) && w_cur_valid && w_eligible;
    assign w_lock_expired = (r_state == S_HOLD) && !w_hold_launch && (r_timer == LOCK_LIM);

    // Bit k of w_rot is the request k positions above the round-robin pointer.
    always_comb begin
        w_rot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_rot[k] = req_valid[wrap_add(r_ptr, (IDX_W+1)'(k))];
        end
    end

    always_comb begin
        w_sel_found = 1'b0;
        w_off       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sel_found = 1'b1;
                w_off       = (IDX_W+1)'(k);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_eligible && w_sel_found) w_next_state = S_LAUNCH;
            S_LAUNCH:    w_next_state = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (tx_busy)             w_next_state = S_WAIT_DONE;
                else if (w_busy_expired) w_next_state = S_IDLE;
            end
            S_WAIT_DONE: if (!tx_busy) w_next_state = r_lock ? S_HOLD : S_IDLE;
            S_HOLD: begin
                if (w_hold_launch)       w_next_state = S_LAUNCH;
                else if (w_lock_expired) w_next_state = S_IDLE;
            end
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Handshake: a requester holds req_valid with stable data/last until it sees req_ack,
    // which pulses only in the launch cycle, coincident with tx_start.
    always_comb begin
        req_ack      = '0;
        tx_start     = (r_state == S_LAUNCH);
        tx_err       = w_busy_expired;
        tx_data      = (r_state == S_LAUNCH) ? w_cur_data : r_tx_data;
        grant_idx    = r_grant;
        grant_active = (r_state != S_IDLE);
        dbg_state    = r_state;
        if (r_state == S_LAUNCH) req_ack[r_grant] = 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_grant   <= '0;
            r_lock    <= 1'b0;
            r_timer   <= '0;
            r_tx_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_eligible && w_sel_found) r_grant <= w_sel_idx;
                S_LAUNCH: begin
                    r_lock    <= ~w_cur_last;
                    r_timer   <= '0;
                    r_tx_data <= w_cur_data;
                end
                S_WAIT_BUSY: begin
                    if (w_busy_expired) begin
                        r_lock <= 1'b0;
                        r_ptr  <= w_next_ptr;
                    end else if (!tx_busy) begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_timer <= '0;
                        if (!r_lock) r_ptr <= w_next_ptr;
                    end
                end
                S_HOLD: begin
                    if (w_lock_expired) begin
                        r_lock <= 1'b0;
                        r_ptr  <= w_next_ptr;
                    end else if (!w_hold_launch) begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester and serializer models, launch scoreboard,
// a table of arbitration vectors and hand-written corner sequences.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int IDX_W        = 2;
    localparam int BUSY_TIMEOUT = 15;
    localparam int LOCK_TIMEOUT = 255;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_HOLD      = 3'd4;

    logic                 sys_clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_last = '0;
    logic [NUM_REQ-1:0]   req_ack;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_active;
    logic                 cts_in = 1'b1;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy = 1'b0;
    logic                 tx_err;
    logic [2:0]           dbg_state;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .BUSY_TIMEOUT(BUSY_TIMEOUT), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ack(req_ack), .grant_idx(grant_idx),
        .grant_active(grant_active), .cts_in(cts_in), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy), .tx_err(tx_err), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 sys_clk = ~sys_clk;

    // ---------------- bench state ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int launches = 0;
    int last_launch_cyc = 0;
    int valid_cyc = 0;
    int err_count = 0;
    int err_cyc = 0;
    int fall_cyc = 0;
    int busy_cnt = 0;
    int ser_len = 160;
    bit ser_en = 1'b1;

    logic [8:0] src_mem [NUM_REQ][32];
    int         src_head [NUM_REQ];
    int         src_tail [NUM_REQ];
    logic [NUM_REQ-1:0] ack_prev = '0;

    logic [9:0] exp_q [$];

    typedef struct {
        logic [3:0]  load;
        int          nbytes;
        logic [3:0]  pkt;
        logic [31:0] order;
        int          n_exp;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    function automatic logic [7:0] mk(input int i, input int v, input int j);
        return {i[1:0], v[2:0], j[2:0]};
    endfunction

    function automatic bit queues_empty();
        for (int i = 0; i < NUM_REQ; i++) if (src_head[i] != src_tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_byte(input int i, input logic [7:0] d, input logic last);
        src_mem[i][src_tail[i]] = {last, d};
        src_tail[i]++;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        bit done = 1'b0;
        while (!done) begin
            @(negedge sys_clk);
            n++;
            if (exp_q.size() == 0 && dbg_state == ST_IDLE && !tx_busy && queues_empty()) done = 1'b1;
            else if (n >= budget) begin
                fail_timeout(name);
                done = 1'b1;
            end
        end
    endtask

    task automatic wait_launch(input int budget, input string name);
        int start = launches;
        int n = 0;
        while (launches == start) begin
            @(negedge sys_clk);
            n++;
            if (launches == start && n >= budget) begin
                fail_timeout(name);
                return;
            end
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        int n = 0;
        while (dbg_state != st) begin
            @(negedge sys_clk);
            n++;
            if (dbg_state != st && n >= budget) begin
                fail_timeout(name);
                return;
            end
        end
    endtask

    // ---------------- monitor, scoreboard, requester and serializer models ----------------
    initial begin
        logic [9:0] exp_e;
        logic [NUM_REQ-1:0] exp_ack;
        bit prev_any;
        forever begin
            @(posedge sys_clk);
            #1;
            cyc++;
            if (tx_start) begin
                launches++;
                last_launch_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL launch_unexpected: got idx %0d data %h, none required", grant_idx, tx_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("launch_idx_data", {22'd0, grant_idx, tx_data}, {22'd0, exp_e});
                end
                exp_ack = '0;
                exp_ack[grant_idx] = 1'b1;
                check("ack_onehot", {28'd0, req_ack}, {28'd0, exp_ack});
            end else begin
                check("ack_without_start", {28'd0, req_ack}, 32'd0);
            end
            if (tx_err) begin
                err_count++;
                err_cyc = cyc;
            end
            for (int i = 0; i < NUM_REQ; i++) if (ack_prev[i]) src_head[i]++;
            ack_prev = req_ack;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    tx_busy = 1'b0;
                    fall_cyc = cyc;
                end
            end
            if (tx_start && ser_en) begin
                busy_cnt = ser_len;
                tx_busy = 1'b1;
            end
            prev_any = |req_valid;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (src_head[i] < src_tail[i]) begin
                    req_valid[i] = 1'b1;
                    req_last[i] = src_mem[i][src_head[i]][8];
                    req_data[8*i +: 8] = src_mem[i][src_head[i]][7:0];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i] = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                end
            end
            if (!prev_any && |req_valid) valid_cyc = cyc;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int start_l;
        int cnt [NUM_REQ];
        logic [1:0] idx;
        int l1;

        // Launch order entries are 2-bit grant indices, entry k at bits [2k+1:2k].
        vecs[0] = '{load: 4'b1111, nbytes: 3, pkt: 4'b0000, order: 32'h0039_3939, n_exp: 12};
        vecs[1] = '{load: 4'b0110, nbytes: 3, pkt: 4'b0100, order: 32'h0000_05A9, n_exp: 6};
        vecs[2] = '{load: 4'b1001, nbytes: 2, pkt: 4'b0001, order: 32'h0000_00C3, n_exp: 4};
        vecs[3] = '{load: 4'b0100, nbytes: 3, pkt: 4'b0000, order: 32'h0000_002A, n_exp: 3};
        vecs[4] = '{load: 4'b1010, nbytes: 2, pkt: 4'b1010, order: 32'h0000_005F, n_exp: 4};

        // Reset values
        repeat (3) @(negedge sys_clk);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_err", {31'd0, tx_err}, 32'd0);
        check("rst_req_ack", {28'd0, req_ack}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_grant", {29'd0, grant_active, grant_idx}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        rst = 1'b0;

        // Single byte, long frame
        @(negedge sys_clk);
        push_byte(0, 8'hA5, 1'b1);
        exp_q.push_back({2'd0, 8'hA5});
        wait_idle(400, "single_byte");
        check("req_to_start", last_launch_cyc - valid_cyc, 1);
        check("single_grant_idx", {30'd0, grant_idx}, 32'd0);
        check("single_data_held", {24'd0, tx_data}, 32'hA5);
        check("single_launches", launches, 1);

        // Arbitration table
        ser_len = 4;
        for (int v = 0; v < 5; v++) begin
            @(negedge sys_clk);
            start_l = launches;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] = 0;
                if (vecs[v].load[i]) begin
                    for (int j = 0; j < vecs[v].nbytes; j++)
                        push_byte(i, mk(i, v, j), vecs[v].pkt[i] ? (j == vecs[v].nbytes - 1) : 1'b1);
                end
            end
            for (int k = 0; k < vecs[v].n_exp; k++) begin
                idx = vecs[v].order[2*k +: 2];
                exp_q.push_back({idx, mk(int'(idx), v, cnt[idx])});
                cnt[idx]++;
            end
            wait_idle(3000, "vector");
            check("vector_launch_count", launches - start_l, vecs[v].n_exp);
        end

        // Byte-to-byte spacing inside a packet
        ser_len = 6;
        @(negedge sys_clk);
        push_byte(0, 8'hB0, 1'b0);
        push_byte(0, 8'hB1, 1'b1);
        exp_q.push_back({2'd0, 8'hB0});
        exp_q.push_back({2'd0, 8'hB1});
        wait_launch(20, "b2b_first");
        wait_launch(40, "b2b_second");
        check("b2b_gap", last_launch_cyc - fall_cyc, 2);
        wait_idle(100, "b2b_drain");

        // CTS gating
        @(negedge sys_clk);
        cts_in = 1'b0;
        start_l = launches;
        push_byte(2, 8'h3C, 1'b1);
        push_byte(2, 8'h3D, 1'b1);
        repeat (20) @(negedge sys_clk);
        check("cts_low_blocks", launches - start_l, 0);
        check("cts_low_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        exp_q.push_back({2'd2, 8'h3C});
        exp_q.push_back({2'd2, 8'h3D});
        cts_in = 1'b1;
        l1 = cyc;
        wait_launch(10, "cts_raise");
        check("cts_raise_latency", (last_launch_cyc - l1 <= 2) ? 32'd1 : 32'd0, 32'd1);
        cts_in = 1'b0;
        repeat (ser_len + 10) @(negedge sys_clk);
        check("cts_drop_frame_done", {31'd0, tx_busy}, 32'd0);
        check("cts_drop_no_launch", launches - start_l, 1);
        cts_in = 1'b1;
        wait_idle(100, "cts_drain");
        check("cts_total", launches - start_l, 2);

        // Serializer never goes busy
        @(negedge sys_clk);
        ser_en = 1'b0;
        push_byte(1, 8'hE1, 1'b1);
        exp_q.push_back({2'd1, 8'hE1});
        wait_launch(10, "busy_to_launch");
        repeat (30) @(negedge sys_clk);
        check("busy_err_once", err_count, 1);
        check("busy_err_time", err_cyc - last_launch_cyc, BUSY_TIMEOUT);
        check("busy_released", {31'd0, grant_active}, 32'd0);
        ser_en = 1'b1;
        push_byte(1, 8'h11, 1'b1);
        push_byte(2, 8'h22, 1'b1);
        exp_q.push_back({2'd2, 8'h22});
        exp_q.push_back({2'd1, 8'h11});
        wait_idle(200, "busy_ptr_advance");

        // Abandoned packet
        @(negedge sys_clk);
        push_byte(0, 8'h40, 1'b0);
        exp_q.push_back({2'd0, 8'h40});
        wait_launch(10, "lock_launch");
        wait_state(ST_HOLD, 50, "lock_hold");
        check("lock_hold_grant", {29'd0, grant_active, grant_idx}, {29'd0, 1'b1, 2'd0});
        push_byte(3, 8'h7E, 1'b1);
        exp_q.push_back({2'd3, 8'h7E});
        wait_launch(400, "lock_release");
        check("lock_release_time", last_launch_cyc - fall_cyc, LOCK_TIMEOUT + 2);
        wait_idle(100, "lock_drain");

        // Reset during WAIT_DONE
        ser_len = 20;
        @(negedge sys_clk);
        push_byte(1, 8'h5A, 1'b1);
        exp_q.push_back({2'd1, 8'h5A});
        wait_state(ST_WAIT_DONE, 30, "rst_wait_done");
        start_l = launches;
        rst = 1'b1;
        @(negedge sys_clk);
        check("midrst_start_err", {30'd0, tx_start, tx_err}, 32'd0);
        check("midrst_ack", {28'd0, req_ack}, 32'd0);
        check("midrst_data", {24'd0, tx_data}, 32'd0);
        check("midrst_grant", {29'd0, grant_active, grant_idx}, 32'd0);
        check("midrst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        rst = 1'b0;
        wait_idle(100, "midrst_drain");
        check("midrst_no_reack", launches - start_l, 0);

        check("final_err_count", err_count, 1);
        check("final_exp_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
